// File: rtl/can_tx_mailbox_slave.sv
// ---------------------------------------------------------------------------
// can_tx_mailbox_slave
//
// AHB slave that stages CAN transmit frames for the protocol core.
// Software fills the TXID / TXDATA_LO / TXDATA_HI staging registers and
// then writes COMMIT to copy the staged frame into a DEPTH-entry FIFO.
// The FIFO head is presented to the CAN core through a valid/ready
// handshake, and completed transmissions are counted in DONECNT.
//
// Ports
//   HCLK      bus clock, rising edge
//   HRESET    asynchronous reset, active-high
//   HADDR     slave-local byte address (address phase)
//   HTRANS    AHB transfer type, bit1 = active transfer
//   HWRITE    1 = write, 0 = read (address phase)
//   HWDATA    write data (data phase)
//   HRDATA    read data (data phase), 0 when no read is in its data phase
//   tx_valid  FIFO head holds a frame
//   tx_id     head frame identifier
//   tx_rtr    head remote-request flag
//   tx_dlc    head data length, already clamped to 0..8
//   tx_data   head payload, byte0 in [7:0]
//   tx_ready  core accepts the head frame on this edge
//   tx_done   one-cycle pulse per frame sent on the bus
//
// Register map (byte addresses)
//   0x00 TXID      R/W  [10:0] id, [11] rtr, [19:16] dlc
//   0x04 TXDATA_LO R/W  bytes 0..3
//   0x08 TXDATA_HI R/W  bytes 4..7
//   0x0C CTRL      W    bit0 COMMIT, bit1 FLUSH (self-clearing, reads 0)
//   0x10 STATUS    R    [4:0] count, [8] full, [9] empty, [16] overflow
//   0x14 DONECNT   R    [15:0] tx_done count
// ---------------------------------------------------------------------------
module can_tx_mailbox_slave #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [31:0]       HWDATA,
   output logic [31:0]       HRDATA,
   output logic              tx_valid,
   output logic [10:0]       tx_id,
   output logic              tx_rtr,
   output logic [3:0]        tx_dlc,
   output logic [63:0]       tx_data,
   input  logic              tx_ready,
   input  logic              tx_done
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int FW = 80;   // frame = {id[10:0], rtr, dlc[3:0], data[63:0]}

   localparam logic [ADDR_W-1:0] A_TXID    = ADDR_W'(16'h0000);
   localparam logic [ADDR_W-1:0] A_DATA_LO = ADDR_W'(16'h0004);
   localparam logic [ADDR_W-1:0] A_DATA_HI = ADDR_W'(16'h0008);
   localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(16'h000C);
   localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(16'h0010);
   localparam logic [ADDR_W-1:0] A_DONECNT = ADDR_W'(16'h0014);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Data length codes above 8 still mean 8 bytes on the wire.
   function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
      return (dlc > 4'd8) ? 4'd8 : dlc;
   endfunction

   // HTRANS[0] only distinguishes SEQ from NONSEQ, which this slave ignores.
   logic unused_bits;
   assign unused_bits = HTRANS[0];

   // ---- address phase -> data phase (p1) ----
   logic              vld_p1;
   logic              write_p1;
   logic [ADDR_W-1:0] addr_p1;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         vld_p1   <= 1'b0;
         write_p1 <= 1'b0;
         addr_p1  <= '0;
      end else begin
         vld_p1 <= HTRANS[1];
         if (HTRANS[1]) begin
            write_p1 <= HWRITE;
            addr_p1  <= HADDR;
         end
      end
   end

   logic wr_p1, rd_p1;
   assign wr_p1 = vld_p1 & write_p1;
   assign rd_p1 = vld_p1 & ~write_p1;

   // ---- staging registers ----
   logic [10:0] stg_id;
   logic        stg_rtr;
   logic [3:0]  stg_dlc;
   logic [31:0] stg_lo;
   logic [31:0] stg_hi;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         stg_id  <= '0;
         stg_rtr <= 1'b0;
         stg_dlc <= '0;
         stg_lo  <= '0;
         stg_hi  <= '0;
      end else if (wr_p1) begin
         if (addr_p1 == A_TXID) begin
            stg_id  <= HWDATA[10:0];
            stg_rtr <= HWDATA[11];
            stg_dlc <= HWDATA[19:16];
         end
         if (addr_p1 == A_DATA_LO) stg_lo <= HWDATA;
         if (addr_p1 == A_DATA_HI) stg_hi <= HWDATA;
      end
   end

   // ---- FIFO control ----
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic          full, empty;
   logic          commit_req, flush_req, pop, push_ok, ovf_set, status_rd;

   assign full       = (count == DEPTH_C);
   assign empty      = (count == '0);
   assign commit_req = wr_p1 && (addr_p1 == A_CTRL) && HWDATA[0];
   assign flush_req  = wr_p1 && (addr_p1 == A_CTRL) && HWDATA[1];
   assign pop        = tx_valid & tx_ready;
   // A pop on the same edge frees a slot, so a commit at full still fits.
   assign push_ok    = commit_req & ~flush_req & (~full | pop);
   assign ovf_set    = commit_req & ~flush_req & full & ~pop;
   assign status_rd  = rd_p1 && (addr_p1 == A_STATUS);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (flush_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
         // A new overflow on the clearing read's edge must not be lost.
         if (ovf_set)        overflow <= 1'b1;
         else if (status_rd) overflow <= 1'b0;
      end
   end

   // ---- FIFO storage ----
   logic [FW-1:0] fifo_mem [DEPTH];
   logic [FW-1:0] frame_in;
   logic [FW-1:0] head;

   assign frame_in = {stg_id, stg_rtr, clamp_dlc(stg_dlc), stg_hi, stg_lo};

   always_ff @(posedge HCLK) begin
      if (push_ok) fifo_mem[wr_ptr] <= frame_in;
   end

   assign head     = fifo_mem[rd_ptr];
   assign tx_valid = ~empty;
   // Gate with tx_valid so the core never sees stale or uninitialised slots.
   assign tx_id    = tx_valid ? head[79:69] : '0;
   assign tx_rtr   = tx_valid & head[68];
   assign tx_dlc   = tx_valid ? head[67:64] : '0;
   assign tx_data  = tx_valid ? head[63:0]  : '0;

   // ---- completed-transmission counter ----
   logic [15:0] done_cnt;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)       done_cnt <= '0;
      else if (tx_done) done_cnt <= done_cnt + 16'd1;
   end

   // ---- read mux (data phase) ----
   always_comb begin
      HRDATA = '0;
      if (rd_p1) begin
         case (addr_p1)
            A_TXID:    HRDATA = {12'b0, stg_dlc, 4'b0, stg_rtr, stg_id};
            A_DATA_LO: HRDATA = stg_lo;
            A_DATA_HI: HRDATA = stg_hi;
            A_STATUS:  HRDATA = {15'b0, overflow, 6'b0, empty, full, 3'b0, 5'(count)};
            A_DONECNT: HRDATA = {16'b0, done_cnt};
            default:   HRDATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_can_tx_mailbox_slave.sv
// ---------------------------------------------------------------------------
// tb_can_tx_mailbox_slave
//
// Directed bench for can_tx_mailbox_slave (DEPTH=4). Inputs change 1 ns
// after the rising edge and outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_can_tx_mailbox_slave;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [15:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        tx_valid;
   logic [10:0] tx_id;
   logic        tx_rtr;
   logic [3:0]  tx_dlc;
   logic [63:0] tx_data;
   logic        tx_ready;
   logic        tx_done;

   int errors = 0;
   int checks = 0;

   can_tx_mailbox_slave #(.DEPTH(4), .ADDR_W(16)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .tx_valid(tx_valid), .tx_id(tx_id), .tx_rtr(tx_rtr), .tx_dlc(tx_dlc),
      .tx_data(tx_data), .tx_ready(tx_ready), .tx_done(tx_done)
   );

   always #5 HCLK = ~HCLK;

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
      HADDR = a; HTRANS = 2'b10; HWRITE = 1'b1;
      step();
      HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
      step();
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
      HADDR = a; HTRANS = 2'b10; HWRITE = 1'b0;
      step();
      HTRANS = 2'b00;
      d = HRDATA;
      step();
   endtask

   task automatic pop_one();
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      bus_write(16'h0000, 32'h0002_0077);
      bus_write(16'h000C, 32'h1);
      bus_write(16'h000C, 32'h1);
      // STATUS read left in its data phase when reset hits
      HADDR = 16'h0010; HTRANS = 2'b10; HWRITE = 1'b0;
      step();
      HTRANS = 2'b00;
      HRESET = 1'b1;
      #1;
      checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got=%h exp=%h", HRDATA, 32'h0); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
      checks++; if (tx_id !== 11'h0) begin errors++; $display("FAIL reset_tx_id got=%h exp=0", tx_id); end
      checks++; if (tx_rtr !== 1'b0) begin errors++; $display("FAIL reset_tx_rtr got=%b exp=0", tx_rtr); end
      checks++; if (tx_dlc !== 4'h0) begin errors++; $display("FAIL reset_tx_dlc got=%h exp=0", tx_dlc); end
      checks++; if (tx_data !== 64'h0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      step();
      bus_read(16'h0010, r);
      checks++; if (r !== 32'h0000_0200) begin errors++; $display("FAIL reset_status got=%h exp=%h", r, 32'h0000_0200); end
      bus_read(16'h0000, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_txid got=%h exp=%h", r, 32'h0); end
   endtask

   task automatic test_single_frame();
      logic [31:0] r;
      bus_write(16'h0000, 32'h0003_0123);
      bus_write(16'h0004, 32'h4433_2211);
      bus_write(16'h000C, 32'h1);
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", tx_valid); end
      checks++; if (tx_id !== 11'h123) begin errors++; $display("FAIL single_id got=%h exp=123", tx_id); end
      checks++; if (tx_dlc !== 4'd3) begin errors++; $display("FAIL single_dlc got=%h exp=3", tx_dlc); end
      checks++; if (tx_rtr !== 1'b0) begin errors++; $display("FAIL single_rtr got=%b exp=0", tx_rtr); end
      checks++; if (tx_data[31:0] !== 32'h4433_2211) begin errors++; $display("FAIL single_data got=%h exp=44332211", tx_data[31:0]); end
      bus_read(16'h0010, r);
      checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL single_status got=%h exp=%h", r, 32'h1); end
      pop_one();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_popped_valid got=%b exp=0", tx_valid); end
      bus_read(16'h0010, r);
      checks++; if (r !== 32'h0000_0200) begin errors++; $display("FAIL single_status_empty got=%h exp=%h", r, 32'h200); end
   endtask

   task automatic test_overflow();
      logic [31:0] r;
      for (int i = 0; i < 5; i++) begin
         bus_write(16'h0000, 32'h0001_0010 + 32'(i));
         bus_write(16'h000C, 32'h1);
      end
      bus_read(16'h0010, r);
      checks++; if (r !== 32'h0001_0104) begin errors++; $display("FAIL ovf_status1 got=%h exp=%h", r, 32'h00010104); end
      bus_read(16'h0010, r);
      checks++; if (r !== 32'h0000_0104) begin errors++; $display("FAIL ovf_status2 got=%h exp=%h", r, 32'h00000104); end
      step();
      checks++; if (tx_id !== 11'h010) begin errors++; $display("FAIL ovf_hold_id got=%h exp=010", tx_id); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (tx_id !== 11'h010 + 11'(i)) begin errors++; $display("FAIL ovf_order_%0d got=%h exp=%h", i, tx_id, 11'h010 + 11'(i)); end
         pop_one();
      end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", tx_valid); end
   endtask

   task automatic test_simultaneous();
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         bus_write(16'h0000, 32'h0000_0020 + 32'(i));
         bus_write(16'h000C, 32'h1);
      end
      bus_write(16'h0000, 32'h0000_0024);
      // COMMIT data phase coincides with a pop while full
      HADDR = 16'h000C; HTRANS = 2'b10; HWRITE = 1'b1;
      step();
      HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h1; tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      bus_read(16'h0010, r);
      checks++; if (r !== 32'h0000_0104) begin errors++; $display("FAIL simul_status got=%h exp=%h", r, 32'h104); end
      checks++; if (tx_id !== 11'h021) begin errors++; $display("FAIL simul_head got=%h exp=021", tx_id); end
      bus_write(16'h000C, 32'h3);
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", tx_valid); end
      bus_read(16'h0010, r);
      checks++; if (r !== 32'h0000_0200) begin errors++; $display("FAIL flush_status got=%h exp=%h", r, 32'h200); end
      // FLUSH with a coincident pop still leaves the FIFO empty
      bus_write(16'h000C, 32'h1);
      bus_write(16'h000C, 32'h1);
      HADDR = 16'h000C; HTRANS = 2'b10; HWRITE = 1'b1;
      step();
      HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h2; tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      bus_read(16'h0010, r);
      checks++; if (r !== 32'h0000_0200) begin errors++; $display("FAIL flushpop_status got=%h exp=%h", r, 32'h200); end
   endtask

   task automatic test_clamp_wrap();
      logic [31:0] r;
      logic [63:0] exp_d;
      bus_write(16'h0000, 32'h000F_0805);
      bus_write(16'h000C, 32'h1);
      checks++; if (tx_dlc !== 4'd8) begin errors++; $display("FAIL clamp_dlc got=%h exp=8", tx_dlc); end
      checks++; if (tx_rtr !== 1'b1) begin errors++; $display("FAIL clamp_rtr got=%b exp=1", tx_rtr); end
      checks++; if (tx_id !== 11'h005) begin errors++; $display("FAIL clamp_id got=%h exp=005", tx_id); end
      bus_read(16'h0000, r);
      checks++; if (r !== 32'h000F_0805) begin errors++; $display("FAIL clamp_txid_rb got=%h exp=%h", r, 32'h000F0805); end
      pop_one();
      bus_write(16'h0000, 32'h0004_0100);
      bus_write(16'h0004, 32'hA000_0000);
      bus_write(16'h0008, 32'h5000_0000);
      bus_write(16'h000C, 32'h1);
      for (int i = 1; i < 9; i++) begin
         bus_write(16'h0004, 32'hA000_0000 + 32'(i));
         bus_write(16'h0008, 32'h5000_0000 + 32'(i));
         bus_write(16'h000C, 32'h1);
         exp_d = {32'h5000_0000 + 32'(i - 1), 32'hA000_0000 + 32'(i - 1)};
         checks++; if (tx_data !== exp_d) begin errors++; $display("FAIL wrap_data_%0d got=%h exp=%h", i - 1, tx_data, exp_d); end
         pop_one();
      end
      exp_d = {32'h5000_0008, 32'hA000_0008};
      checks++; if (tx_data !== exp_d) begin errors++; $display("FAIL wrap_data_8 got=%h exp=%h", tx_data, exp_d); end
      pop_one();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained got=%b exp=0", tx_valid); end
   endtask

   task automatic test_donecnt();
      logic [31:0] r;
      for (int i = 0; i < 3; i++) begin
         tx_done = 1'b1; step();
         tx_done = 1'b0; step();
      end
      bus_read(16'h0014, r);
      checks++; if (r !== 32'd3) begin errors++; $display("FAIL donecnt_3 got=%h exp=%h", r, 32'd3); end
      tx_done = 1'b1;
      for (int i = 0; i < 32'h0000_FFFE; i++) step();
      tx_done = 1'b0;
      bus_read(16'h0014, r);
      checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL donecnt_wrap got=%h exp=%h", r, 32'h1); end
      bus_write(16'h0014, 32'h0000_1234);
      bus_read(16'h0014, r);
      checks++; if (r !== 32'h0000_0001) begin errors++; $display("FAIL donecnt_wr_ignored got=%h exp=%h", r, 32'h1); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      HADDR = 16'h0000; HTRANS = 2'b10; HWRITE = 1'b1;
      step();
      HWDATA = 32'h0005_0ABC; HADDR = 16'h0000; HTRANS = 2'b10; HWRITE = 1'b0;
      step();
      HTRANS = 2'b00;
      r = HRDATA;
      checks++; if (r !== 32'h0005_0ABC) begin errors++; $display("FAIL b2b_txid got=%h exp=%h", r, 32'h00050ABC); end
      step();
      checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL b2b_idle_hrdata got=%h exp=0", HRDATA); end
      bus_read(16'h0018, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", r); end
      bus_read(16'h000C, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL ctrl_read got=%h exp=0", r); end
   endtask

   initial begin
      HRESET = 1'b1; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = '0;
      tx_ready = 1'b0; tx_done = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      step();
      test_reset();
      test_single_frame();
      test_overflow();
      test_simultaneous();
      test_clamp_wrap();
      test_donecnt();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/can_tx_mailbox_slave.md
Name: can_tx_mailbox_slave

Overview:
- AHB slave that sits on one decoded slave port of the bus arbitrator and stages CAN transmit frames for the protocol core.
- Software writes ID, DLC and data into staging registers, then commits them into a DEPTH-entry FIFO.
- The block presents the FIFO head to the CAN core with a valid/ready handshake and counts completed transmissions.

Parameters:
DEPTH, 4, TX FIFO entries; power of two, 2..16
ADDR_W, 16, slave-side address width (low half of the master address)

Ports:
HCLK  input  1  bus clock, rising edge
HRESET  input  1  asynchronous reset, active-high
HADDR  input  ADDR_W  slave-local address
HTRANS  input  2  AHB transfer type; bit1=1 means an active transfer
HWRITE  input  1  1=write, 0=read
HWDATA  input  32  write data, valid in the data phase
HRDATA  output  32  read data, valid in the data phase
tx_valid  output  1  FIFO head is valid
tx_id  output  11  head frame identifier
tx_rtr  output  1  head remote-request flag
tx_dlc  output  4  head data length, 0..8
tx_data  output  64  head data; byte0 = [7:0]
tx_ready  input  1  core accepts the head frame
tx_done  input  1  one-cycle pulse per frame sent on the bus

Behaviour:
- Reset (async, HRESET=1): staging registers, FIFO pointers, count, overflow flag and done counter are all 0.
  - Outputs: HRDATA=0, tx_valid=0, tx_id/tx_rtr/tx_dlc/tx_data=0.
- AHB pipelining, zero wait states:
  - Address phase: when HTRANS[1]=1, latch HADDR and HWRITE into data-phase registers together with a phase-valid bit.
  - Data phase (next cycle): a write commits HWDATA at the end of that cycle. A read drives HRDATA from the latched address during that cycle.
  - If no data phase is valid, HRDATA=0.
  - Back-to-back transfers are supported every cycle.
- Register map (byte addresses):
  - 0x00 TXID (R/W): [10:0] id, [11] rtr, [19:16] dlc.
  - 0x04 TXDATA_LO (R/W): bytes 0..3.
  - 0x08 TXDATA_HI (R/W): bytes 4..7.
  - 0x0C CTRL (W): bit0 COMMIT, bit1 FLUSH; self-clearing; reads 0.
  - 0x10 STATUS (R): [4:0] count, [8] full, [9] empty, [16] overflow.
  - 0x14 DONECNT (R): [15:0] tx_done count, wraps 0xFFFF->0; writes ignored.
  - Any other address: reads 0, writes ignored.
- COMMIT: pushes {id, rtr, min(dlc,8), data} into the FIFO on the data-phase edge. Staging registers are kept, so the same frame can be re-sent.
- Full behaviour: COMMIT while full drops the frame and sets the overflow flag (sticky).
  - Exception: if a pop happens in the same cycle, the push is accepted and overflow is not set.
- FLUSH: empties the FIFO (pointers and count to 0) on the data-phase edge.
  - If COMMIT and FLUSH are both set, FLUSH wins and nothing is pushed.
  - If a pop coincides with FLUSH, the result is still empty.
  - tx_valid falls the next cycle.
- Pop: occurs on any edge where tx_valid & tx_ready.
  - tx_* outputs come straight from the FIFO head (no extra latency).
  - Head data holds stable while tx_valid=1 and tx_ready=0.
- Count rules: count = pushes minus pops, range 0..DEPTH.
  - full = (count==DEPTH), empty = (count==0).
  - Pointers wrap modulo DEPTH.
- Overflow clear: a STATUS read clears overflow at the end of its data phase.
  - If a new overflow occurs in that same cycle, overflow stays 1.
- DONECNT: increments by 1 on every tx_done pulse, independent of FIFO state.

Test Plan:
- Reset check: assert HRESET mid-transfer with 2 frames queued -> all outputs 0 and STATUS reads 0x00000200 after release.
- Single frame: write TXID=0x0003_0123, LO=0x44332211, CTRL=1, with tx_ready=0 -> next cycle tx_valid=1, tx_id=0x123, tx_dlc=3, tx_data[31:0]=0x44332211; STATUS count=1. Then pulse tx_ready for 1 cycle -> tx_valid=0 and count=0.
- Overflow: commit 5 frames with DEPTH=4 and tx_ready=0 -> STATUS=0x00010104. A second STATUS read returns 0x00000104. The FIFO holds the first 4 frames in order.
- Simultaneous events at full:
  - COMMIT on the same edge as a tx_valid&tx_ready pop -> count stays 4 and overflow stays 0.
  - COMMIT|FLUSH (CTRL=3) -> count=0 and tx_valid=0 next cycle.
- Clamp and wrap: TXID dlc=0xF -> tx_dlc=8. Push/pop 9 frames through -> pointers wrap and data order is preserved.
- DONECNT: 0x10001 tx_done pulses -> DONECNT reads 0x0001. Back-to-back write then read of TXID -> read returns the just-written value.
